// File: rtl/seed_dec_core_if.sv
// Host-side bundle for seed_dec_core: block start/result handshake plus the
// combinational round-key lookup (index out, key back in the same cycle).
interface seed_dec_core_if;
    logic         i_Start;
    logic [127:0] i_Data;
    logic [63:0]  i_RoundKey;
    logic [3:0]   o_KeyIdx;
    logic         o_Ready;
    logic         o_Valid;
    logic [127:0] o_Data;

    modport master (
        output i_Start, i_Data, i_RoundKey,
        input  o_KeyIdx, o_Ready, o_Valid, o_Data
    );
    modport slave (
        input  i_Start, i_Data, i_RoundKey,
        output o_KeyIdx, o_Ready, o_Valid, o_Data
    );
endinterface

// File: rtl/seed_dec_core.sv
// Iterative SEED-128 decryption: one shared G evaluation per cycle, three
// cycles per Feistel round, round keys fetched in reverse order (15 -> 0).
module seed_dec_core #(
    parameter int ROUNDS = 16
) (
    input  logic           i_Clk,
    input  logic           i_Rst,
    seed_dec_core_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for i_Start, o_Ready high
    // PA    | key mix, G(C^K0^D^K1), set T1 and T0
    // PB    | G(T0), accumulate into T1
    // PC    | G(T1), finish F, swap halves or emit plaintext
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PA   = 2'd1;
    localparam logic [1:0] ST_PB   = 2'd2;
    localparam logic [1:0] ST_PC   = 2'd3;

    localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);
    localparam logic [7:0] M0 = 8'hFC, M1 = 8'hF3, M2 = 8'hCF, M3 = 8'h3F;

    localparam logic [2047:0] S1_TAB = {
        128'hA985D6D3541DAC255D43181E51FCCA63, 128'h2844209DE0E2C817A58F037BBB13D2EE,
        128'h708C3FA832DDF674EC950B575C5BBD01, 128'h241C739810CCF2D92CE772839BD186C9,
        128'h6050A3EB0DB69E4FB75AC678A612AFD5, 128'h61C3B441527D8D081F9900190453F7E1,
        128'hFD762F27B08B0EABA26E934D697C090A, 128'hBFEFF3C58714FE64DE2E4B1A06216B66,
        128'h02F5928A0CB37ED07A4796E52680ADDF, 128'hA13037AE36152238F4A7454C81E98497,
        128'h35CBCE3C7111C78975FBDAF8945982C4, 128'hFF493967C0CFD7B80F8E4223916CDBA4,
        128'h34F148C26F3D2D40BE3EBCC1AABA4E55, 128'h3BDC687F9CD84A5677A0ED46B52B65FA,
        128'hE3B9B19F5EF9E6B231EA6D5FE4F0CD88, 128'h163A58D462290733E81B0579906A2A9A
    };
    localparam logic [2047:0] S2_TAB = {
        128'h38E82DA6CFDEB3B8AF6055C7446F6B5B, 128'hC36233B529A0E2A7D39111061CBC364B,
        128'hEF886CA817C416F4C245E1D63F3D8E98, 128'h284EF63EA5F90DDFD82B667A272FF172,
        128'h42D441C07367AC8BF7AD801FCA2CAA34, 128'hD20BEEE95D9418F857AE08C513CD86B9,
        128'hFF7DC131F58A6AB1D120D70222046871, 128'h07DB9D9961BEE659DD5190DC9AA3ABD0,
        128'h810F471AE3EC8DBF967B5CA2A163234D, 128'hC89E9C3A0C2EBA6E9F5AF292F34978CC,
        128'h15FB70757F351003646DC674D5B4EA09, 128'h7619FE4012E0BD05FA01F02A5EA95643,
        128'h8514899BB0E5487997FC1E82218C1B5F, 128'h7754B21D254F0046ED5852EB7EDAC9FD,
        128'h3095653CB6E4BB7C0E50392632846993, 128'h37E724A4CB530A87D94C838FCE3B4AB7
    };

    // Entry 0 sits in the top byte, so byte x starts at bit 8*(255-x).
    function automatic logic [7:0] s1(input logic [7:0] x);
        return S1_TAB[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] s2(input logic [7:0] x);
        return S2_TAB[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] g_func(input logic [31:0] x);
        logic [7:0] y0, y1, y2, y3;
        y0 = s1(x[7:0]);
        y1 = s2(x[15:8]);
        y2 = s1(x[23:16]);
        y3 = s2(x[31:24]);
        return {y0 & M3, y0 & M2, y0 & M1, y0 & M0}
             ^ {y1 & M0, y1 & M3, y1 & M2, y1 & M1}
             ^ {y2 & M1, y2 & M0, y2 & M3, y2 & M2}
             ^ {y3 & M2, y3 & M1, y3 & M0, y3 & M3};
    endfunction

    logic [1:0]   r_State;
    logic [63:0]  r_L, r_R;
    logic [31:0]  r_T0, r_T1;
    logic [3:0]   r_Rnd;
    logic         r_Valid;
    logic [127:0] r_Data;

    logic [31:0]  w_T0Mix, w_GIn, w_G;
    logic [63:0]  w_F;

    assign w_T0Mix = r_R[63:32] ^ bus.i_RoundKey[63:32];

    always_comb begin
        w_GIn = r_T1;
        case (r_State)
            ST_PA:   w_GIn = w_T0Mix ^ r_R[31:0] ^ bus.i_RoundKey[31:0];
            ST_PB:   w_GIn = r_T0;
            default: w_GIn = r_T1;
        endcase
    end

    assign w_G = g_func(w_GIn);
    assign w_F = {r_T0 + w_G, w_G};

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State <= ST_IDLE;
            r_L     <= '0;
            r_R     <= '0;
            r_T0    <= '0;
            r_T1    <= '0;
            r_Rnd   <= '0;
            r_Valid <= 1'b0;
            r_Data  <= '0;
        end else begin
            r_Valid <= 1'b0;
            case (r_State)
                ST_IDLE: begin
                    if (bus.i_Start) begin
                        r_L     <= bus.i_Data[127:64];
                        r_R     <= bus.i_Data[63:0];
                        r_Rnd   <= '0;
                        r_State <= ST_PA;
                    end
                end
                ST_PA: begin
                    r_T1    <= w_G;
                    r_T0    <= w_T0Mix + w_G;
                    r_State <= ST_PB;
                end
                ST_PB: begin
                    r_T0    <= w_G;
                    r_T1    <= r_T1 + w_G;
                    r_State <= ST_PC;
                end
                default: begin
                    // Last round keeps the halves in place; rnd is cleared so
                    // the idle key index reads 15.
                    if (r_Rnd == LAST_RND) begin
                        r_Data  <= {r_L ^ w_F, r_R};
                        r_Valid <= 1'b1;
                        r_Rnd   <= '0;
                        r_State <= ST_IDLE;
                    end else begin
                        r_L     <= r_R;
                        r_R     <= r_L ^ w_F;
                        r_Rnd   <= r_Rnd + 4'd1;
                        r_State <= ST_PA;
                    end
                end
            endcase
        end
    end

    assign bus.o_Ready  = (r_State == ST_IDLE);
    assign bus.o_Valid  = r_Valid;
    assign bus.o_Data   = r_Data;
    assign bus.o_KeyIdx = LAST_RND - r_Rnd;
endmodule

// File: tb/tb_seed_dec_core.sv
// Bench for seed_dec_core: published SEED vectors from a table, then random
// round trips through an encryption model and multi-cycle corner sequences.
module tb_seed_dec_core;
    localparam logic [2047:0] S1_T = {
        128'hA985D6D3541DAC255D43181E51FCCA63, 128'h2844209DE0E2C817A58F037BBB13D2EE,
        128'h708C3FA832DDF674EC950B575C5BBD01, 128'h241C739810CCF2D92CE772839BD186C9,
        128'h6050A3EB0DB69E4FB75AC678A612AFD5, 128'h61C3B441527D8D081F9900190453F7E1,
        128'hFD762F27B08B0EABA26E934D697C090A, 128'hBFEFF3C58714FE64DE2E4B1A06216B66,
        128'h02F5928A0CB37ED07A4796E52680ADDF, 128'hA13037AE36152238F4A7454C81E98497,
        128'h35CBCE3C7111C78975FBDAF8945982C4, 128'hFF493967C0CFD7B80F8E4223916CDBA4,
        128'h34F148C26F3D2D40BE3EBCC1AABA4E55, 128'h3BDC687F9CD84A5677A0ED46B52B65FA,
        128'hE3B9B19F5EF9E6B231EA6D5FE4F0CD88, 128'h163A58D462290733E81B0579906A2A9A
    };
    localparam logic [2047:0] S2_T = {
        128'h38E82DA6CFDEB3B8AF6055C7446F6B5B, 128'hC36233B529A0E2A7D39111061CBC364B,
        128'hEF886CA817C416F4C245E1D63F3D8E98, 128'h284EF63EA5F90DDFD82B667A272FF172,
        128'h42D441C07367AC8BF7AD801FCA2CAA34, 128'hD20BEEE95D9418F857AE08C513CD86B9,
        128'hFF7DC131F58A6AB1D120D70222046871, 128'h07DB9D9961BEE659DD5190DC9AA3ABD0,
        128'h810F471AE3EC8DBF967B5CA2A163234D, 128'hC89E9C3A0C2EBA6E9F5AF292F34978CC,
        128'h15FB70757F351003646DC674D5B4EA09, 128'h7619FE4012E0BD05FA01F02A5EA95643,
        128'h8514899BB0E5487997FC1E82218C1B5F, 128'h7754B21D254F0046ED5852EB7EDAC9FD,
        128'h3095653CB6E4BB7C0E50392632846993, 128'h37E724A4CB530A87D94C838FCE3B4AB7
    };

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seed_dec_core_if bus ();
    seed_dec_core #(.ROUNDS(16)) dut (.i_Clk(clk), .i_Rst(rst), .bus(bus));

    logic [63:0] rk [16];
    assign bus.i_RoundKey = rk[bus.o_KeyIdx];

    int checks = 0;
    int errors = 0;
    logic [3:0] key_log [1:48];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] g_ref(input logic [31:0] x);
        logic [7:0] y0, y1, y2, y3, z0, z1, z2, z3;
        y0 = S1_T[{~x[7:0], 3'b000} +: 8];
        y1 = S2_T[{~x[15:8], 3'b000} +: 8];
        y2 = S1_T[{~x[23:16], 3'b000} +: 8];
        y3 = S2_T[{~x[31:24], 3'b000} +: 8];
        z3 = (y0 & 8'h3F) ^ (y1 & 8'hFC) ^ (y2 & 8'hF3) ^ (y3 & 8'hCF);
        z2 = (y0 & 8'hCF) ^ (y1 & 8'h3F) ^ (y2 & 8'hFC) ^ (y3 & 8'hF3);
        z1 = (y0 & 8'hF3) ^ (y1 & 8'hCF) ^ (y2 & 8'h3F) ^ (y3 & 8'hFC);
        z0 = (y0 & 8'hFC) ^ (y1 & 8'hF3) ^ (y2 & 8'hCF) ^ (y3 & 8'h3F);
        return {z3, z2, z1, z0};
    endfunction

    function automatic logic [63:0] f_ref(input logic [63:0] r, input logic [63:0] k);
        logic [31:0] c1, d1, g1, c2, d3;
        c1 = r[63:32] ^ k[63:32];
        d1 = r[31:0] ^ k[31:0];
        g1 = g_ref(c1 ^ d1);
        c2 = g_ref(c1 + g1);
        d3 = g_ref(g1 + c2);
        return {c2 + d3, d3};
    endfunction

    task automatic key_sched(input logic [127:0] key);
        logic [31:0] a, b, c, d, kc;
        logic [63:0] t;
        {a, b, c, d} = key;
        kc = 32'h9E3779B9;
        for (int i = 0; i < 16; i++) begin
            rk[i] = {g_ref(a + c - kc), g_ref(b - d + kc)};
            if (i % 2 == 0) begin
                t = {a, b};
                {a, b} = {t[7:0], t[63:8]};
            end else begin
                t = {c, d};
                {c, d} = {t[55:0], t[63:56]};
            end
            kc = {kc[30:0], kc[31]};
        end
    endtask

    function automatic logic [127:0] enc_ref(input logic [127:0] pt);
        logic [63:0] l, r, nr;
        {l, r} = pt;
        for (int i = 0; i < 15; i++) begin
            nr = l ^ f_ref(r, rk[i]);
            l  = r;
            r  = nr;
        end
        return {l ^ f_ref(r, rk[15]), r};
    endfunction

    // Carry-outs of t0+g (PA) and T1+g (PB) in the first decryption round.
    function automatic logic [1:0] first_carries(input logic [127:0] ct);
        logic [31:0] t0, g1, g2;
        logic [32:0] s1, s2;
        t0 = ct[63:32] ^ rk[15][63:32];
        g1 = g_ref(t0 ^ ct[31:0] ^ rk[15][31:0]);
        s1 = {1'b0, t0} + {1'b0, g1};
        g2 = g_ref(s1[31:0]);
        s2 = {1'b0, g1} + {1'b0, g2};
        return {s1[32], s2[32]};
    endfunction

    task automatic issue(input logic [127:0] ct);
        bus.i_Start = 1'b1;
        bus.i_Data  = ct;
        @(negedge clk);
        bus.i_Start = 1'b0;
        bus.i_Data  = ~ct;
    endtask

    // Entered at the negedge of cycle t+1; returns at the o_Valid negedge.
    task automatic collect(input logic [127:0] exp, input bit busy_pulses);
        int n;
        int bad_ready;
        int lat;
        n = 1;
        bad_ready = 0;
        while (n <= 60 && !bus.o_Valid) begin
            if (n <= 48) key_log[n] = bus.o_KeyIdx;
            if (bus.o_Ready) bad_ready++;
            bus.i_Start = busy_pulses && (n == 10 || n == 30);
            @(negedge clk);
            n++;
        end
        bus.i_Start = 1'b0;
        lat = bus.o_Valid ? n : 0;
        chk("latency", 128'(lat), 128'd49);
        chk("ready_low_busy", 128'(bad_ready), 128'd0);
        chk("ready_at_valid", 128'(bus.o_Ready), 128'd1);
        chk("plaintext", bus.o_Data, exp);
    endtask

    task automatic after_valid(input logic [127:0] exp);
        @(negedge clk);
        chk("valid_one_cycle", 128'(bus.o_Valid), 128'd0);
        chk("data_held", bus.o_Data, exp);
        chk("keyidx_idle", 128'(bus.o_KeyIdx), 128'd15);
    endtask

    vec_t vecs[4];

    initial begin
        logic [127:0] key, pa, pb, ca, cb;
        logic [1:0] cy;
        int nvalid, nbusy;
        bit found;

        vecs[0] = '{128'h0, 128'h5EBAC6E0054E166819AFF1CC6D346CDB,
                    128'h000102030405060708090A0B0C0D0E0F};
        vecs[1] = '{128'h000102030405060708090A0B0C0D0E0F,
                    128'hC11F22F20140505084483597E4370F43, 128'h0};
        vecs[2] = '{128'h4706480851E61BE85D74BFB3FD956185,
                    128'hEE54D13EBCAE706D226BC3142CD40D4A,
                    128'h83A2F8A288641FB9A4E9A5CC2F131C7D};
        vecs[3] = '{128'h28DBC3BC49FFD87DCFA509B11D422BE7,
                    128'h9B9B7BFCD1813CB95D0B3618F40F5122,
                    128'hB41E6BE2EBA84A148E2EED84593C5EC7};

        rst = 1'b1;
        bus.i_Start = 1'b0;
        bus.i_Data  = '0;
        key_sched(128'h0);
        repeat (3) @(negedge clk);
        chk("rst_ready", 128'(bus.o_Ready), 128'd1);
        chk("rst_valid", 128'(bus.o_Valid), 128'd0);
        chk("rst_data", bus.o_Data, 128'd0);
        chk("rst_keyidx", 128'(bus.o_KeyIdx), 128'd15);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            key_sched(vecs[v].key);
            issue(vecs[v].ct);
            collect(vecs[v].pt, 1'b0);
            if (v == 0) begin
                for (int i = 1; i <= 48; i++)
                    chk("keyidx_seq", 128'(key_log[i]), 128'(15 - (i - 1) / 3));
            end
            after_valid(vecs[v].pt);
        end

        // Back-to-back: second start issued in the first block's o_Valid cycle.
        key = {$urandom, $urandom, $urandom, $urandom};
        key_sched(key);
        pa = {$urandom, $urandom, $urandom, $urandom};
        pb = {$urandom, $urandom, $urandom, $urandom};
        ca = enc_ref(pa);
        cb = enc_ref(pb);
        issue(ca);
        collect(pa, 1'b0);
        issue(cb);
        collect(pb, 1'b0);
        after_valid(pb);

        for (int it = 0; it < 198; it++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            key_sched(key);
            pa = {$urandom, $urandom, $urandom, $urandom};
            issue(enc_ref(pa));
            collect(pa, 1'b0);
            @(negedge clk);
        end

        // Starts while busy must be ignored.
        key_sched(vecs[2].key);
        issue(vecs[2].ct);
        collect(vecs[2].pt, 1'b1);
        nvalid = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.o_Valid) nvalid++;
        end
        chk("busy_extra_valid", 128'(nvalid), 128'd0);
        chk("busy_data_held", bus.o_Data, vecs[2].pt);

        // Reset at t+20 together with a start that must also be ignored.
        key_sched(vecs[3].key);
        issue(vecs[3].ct);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        bus.i_Start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_Start = 1'b0;
        chk("abort_ready", 128'(bus.o_Ready), 128'd1);
        chk("abort_data", bus.o_Data, 128'd0);
        chk("abort_keyidx", 128'(bus.o_KeyIdx), 128'd15);
        nvalid = 0;
        nbusy = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.o_Valid) nvalid++;
            if (!bus.o_Ready) nbusy++;
        end
        chk("abort_no_valid", 128'(nvalid), 128'd0);
        chk("abort_stays_idle", 128'(nbusy), 128'd0);
        issue(vecs[3].ct);
        collect(vecs[3].pt, 1'b0);
        after_valid(vecs[3].pt);

        // Pick a block whose first round overflows both 32-bit adds.
        key = {$urandom, $urandom, $urandom, $urandom};
        key_sched(key);
        found = 1'b0;
        pa = '0;
        ca = '0;
        for (int t = 0; t < 2000 && !found; t++) begin
            pa = {$urandom, $urandom, $urandom, $urandom};
            ca = enc_ref(pa);
            cy = first_carries(ca);
            found = (cy == 2'b11);
        end
        chk("wrap_found", 128'(found), 128'd1);
        issue(ca);
        collect(pa, 1'b0);
        after_valid(pa);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
